// File: rtl/vms_pkg.sv
// Shared types and sizing helpers for the vector memory sequencer.
package vms_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } vms_state_t;

  localparam int LANES_DEF  = 4;
  localparam int LANE_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  localparam int LANE_BYTES = LANE_W_DEF / 8;

  // Lane counter width; a single-lane build still needs one bit.
  function automatic int lane_idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/vms_lane_buffer.sv
// LANES x LANE_W register file: bulk or lane-indexed write, lane-indexed read.
module vms_lane_buffer
  import vms_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int LANE_W = LANE_W_DEF,
  parameter int IW     = lane_idx_w(LANES_DEF)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_all,
  input  logic [LANES*LANE_W-1:0] wr_all_data,
  input  logic                    wr_en,
  input  logic [IW-1:0]           wr_idx,
  input  logic [LANE_W-1:0]       wr_data,
  input  logic [IW-1:0]           rd_idx,
  output logic [LANE_W-1:0]       rd_data,
  output logic [LANES*LANE_W-1:0] q
);

  logic [LANES-1:0][LANE_W-1:0] mem;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem <= '0;
    end else if (wr_all) begin
      mem <= wr_all_data;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];
  assign q       = mem;

endmodule

// File: rtl/vector_mem_sequencer.sv
// Splits 128-bit vector loads/stores into word transfers and stalls decode
// until the whole vector has moved.
//
//   state | meaning
//   IDLE  | waiting for start_load / start_store
//   XFER  | one lane request outstanding, advance on mem_ack
//   DONE  | single completion cycle, pulse load_valid / store_done
module vector_mem_sequencer
  import vms_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int LANE_W = LANE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_load,
  input  logic                    start_store,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [LANES*LANE_W-1:0] store_data,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LANE_W-1:0]       mem_wdata,
  input  logic [LANE_W-1:0]       mem_rdata,
  input  logic                    mem_ack,
  output logic [LANES*LANE_W-1:0] load_data,
  output logic                    load_valid,
  output logic                    store_done,
  output logic                    busy,
  output logic                    stuck
);

  localparam int IW   = lane_idx_w(LANES);
  localparam int STEP = LANE_W / 8;
  localparam logic [IW-1:0] LAST_LANE = IW'(LANES - 1);

  vms_state_t         state_q, state_d;
  logic [IW-1:0]      lane_q;
  logic [ADDR_W-1:0]  base_q;
  logic               we_q;
  logic               accept;
  logic               capture;
  logic [LANE_W-1:0]  st_lane;
  logic [ADDR_W-1:0]  lane_off;

  logic [LANES*LANE_W-1:0] st_q_unused;
  logic [LANE_W-1:0]       ld_rd_unused;

  // Load wins when both starts arrive together.
  assign accept   = (state_q == IDLE) && (start_load || start_store);
  assign capture  = (state_q == XFER) && mem_ack && !we_q;
  assign lane_off = ADDR_W'(lane_q) * ADDR_W'(STEP);
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        base_q <= base_addr;
        we_q   <= !start_load;
        lane_q <= '0;
      end else if ((state_q == XFER) && mem_ack && (lane_q != LAST_LANE)) begin
        lane_q <= lane_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    load_valid = 1'b0;
    store_done = 1'b0;
    stuck      = 1'b0;
    case (state_q)
      IDLE: begin
        stuck = start_load || start_store;
        if (stuck) state_d = XFER;
      end
      XFER: begin
        stuck     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = base_q + lane_off;
        mem_wdata = we_q ? st_lane : '0;
        if (mem_ack && (lane_q == LAST_LANE)) state_d = DONE;
      end
      DONE: begin
        // stuck stays low here so the stalled instruction retires this cycle
        load_valid = !we_q;
        store_done = we_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  vms_lane_buffer #(.LANES(LANES), .LANE_W(LANE_W), .IW(IW)) u_st_buf (
    .clk         (clk),
    .rst         (rst),
    .wr_all      (accept && !start_load),
    .wr_all_data (store_data),
    .wr_en       (1'b0),
    .wr_idx      ('0),
    .wr_data     ('0),
    .rd_idx      (lane_q),
    .rd_data     (st_lane),
    .q           (st_q_unused)
  );

  // Separate load buffer so a store never disturbs the last load result.
  vms_lane_buffer #(.LANES(LANES), .LANE_W(LANE_W), .IW(IW)) u_ld_buf (
    .clk         (clk),
    .rst         (rst),
    .wr_all      (1'b0),
    .wr_all_data ('0),
    .wr_en       (capture),
    .wr_idx      (lane_q),
    .wr_data     (mem_rdata),
    .rd_idx      ('0),
    .rd_data     (ld_rd_unused),
    .q           (load_data)
  );

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer with a queue-based scoreboard of
// expected lane transfers and completions.
module tb_vector_mem_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_load = 1'b0;
  logic         start_store = 1'b0;
  logic [31:0]  base_addr = '0;
  logic [127:0] store_data = '0;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr, mem_wdata;
  logic [31:0]  mem_rdata = '0;
  logic         mem_ack = 1'b0;
  logic [127:0] load_data;
  logic         load_valid, store_done, busy, stuck;

  always #5 clk = ~clk;

  vector_mem_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start_load  (start_load),
    .start_store (start_store),
    .base_addr   (base_addr),
    .store_data  (store_data),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .store_done  (store_done),
    .busy        (busy),
    .stuck       (stuck)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t        exp_xfer[$];
  logic [127:0] exp_load[$];
  int           exp_store[$];
  logic [127:0] last_load = '0;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every request must match the queue head; pop on ack.
  always @(negedge clk) begin
    if (mem_req) begin
      chk("req_expected", 128'(exp_xfer.size() != 0), 128'(1));
      if (exp_xfer.size() != 0) begin
        chk("mem_addr", mem_addr, exp_xfer[0].addr);
        chk("mem_we", mem_we, exp_xfer[0].we);
        chk("mem_wdata", mem_wdata, exp_xfer[0].wdata);
        if (mem_ack) void'(exp_xfer.pop_front());
      end
    end
    if (load_valid) begin
      chk("load_expected", 128'(exp_load.size() != 0), 128'(1));
      if (exp_load.size() != 0) chk("load_data", load_data, exp_load.pop_front());
    end
    if (store_done) begin
      chk("store_expected", 128'(exp_store.size() != 0), 128'(1));
      if (exp_store.size() != 0) void'(exp_store.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1; the start cycle is cycle t.
  task automatic run_vec(input bit ld, input bit st, input logic [31:0] base,
                         input logic [127:0] sdata, input logic [127:0] rdata,
                         input int waits, input int poke_lane, input bit done_poke);
    bit is_ld;
    is_ld = ld;
    start_load  = ld;
    start_store = st;
    base_addr   = base;
    store_data  = sdata;
    for (int i = 0; i < 4; i++)
      exp_xfer.push_back('{addr: base + 32'(i * 4), we: !is_ld,
                           wdata: is_ld ? 32'h0 : sdata[i*32 +: 32]});
    if (is_ld) exp_load.push_back(rdata);
    else exp_store.push_back(1);
    #3;
    chk("stuck_start", stuck, 1);
    chk("busy_start", busy, 0);
    tick();
    start_load  = 1'b0;
    start_store = 1'b0;
    base_addr   = $urandom;
    store_data  = {$urandom, $urandom, $urandom, $urandom};
    for (int lane = 0; lane < 4; lane++) begin
      for (int w = 0; w <= waits; w++) begin
        if (lane == poke_lane && w == 0) begin
          start_load  = 1'b1;
          start_store = 1'b1;
        end
        mem_ack   = (w == waits);
        mem_rdata = (is_ld && w == waits) ? rdata[lane*32 +: 32] : $urandom;
        #3;
        chk("stuck_xfer", stuck, 1);
        chk("busy_xfer", busy, 1);
        tick();
        start_load  = 1'b0;
        start_store = 1'b0;
        mem_ack     = 1'b0;
      end
    end
    if (done_poke) start_load = 1'b1;
    #3;
    chk("load_valid_done", load_valid, is_ld);
    chk("store_done_done", store_done, !is_ld);
    chk("stuck_done", stuck, 0);
    chk("req_done", mem_req, 0);
    tick();
    start_load = 1'b0;
    if (is_ld) last_load = rdata;
    #3;
    chk("busy_after", busy, 0);
    chk("load_valid_after", load_valid, 0);
    chk("store_done_after", store_done, 0);
    chk("load_data_hold", load_data, last_load);
    tick();
  endtask

  initial begin
    tick();
    tick();
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_load_valid", load_valid, 0);
    chk("rst_store_done", store_done, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    tick();

    // zero-wait load
    run_vec(1, 0, 32'h100, '0, 128'h00000044_00000033_00000022_00000011, 0, -1, 0);
    // store with two wait cycles per lane, plus a start in DONE that must be ignored
    run_vec(0, 1, 32'h200, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, '0, 2, -1, 1);
    // simultaneous starts: load wins
    run_vec(1, 1, 32'h180, 128'h13579BDF_2468ACE0_0F0F0F0F_F0F0F0F0, '0, 0, -1, 0);
    // wrap-around addressing
    run_vec(1, 0, 32'hFFFF_FFF8, '0, 128'hCAFE0004_CAFE0003_CAFE0002_CAFE0001, 1, -1, 0);
    // starts during XFER are ignored
    run_vec(0, 1, 32'h400, 128'h44444444_33333333_22222222_11111111, '0, 1, 1, 0);

    // stray ack in IDLE
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("stray_req", mem_req, 0);
      chk("stray_busy", busy, 0);
      chk("stray_addr", mem_addr, 0);
      chk("stray_load_data", load_data, last_load);
      chk("stray_load_valid", load_valid, 0);
      tick();
    end
    mem_ack = 1'b0;

    // reset during lane 2 of a load
    start_load = 1'b1;
    base_addr  = 32'h300;
    for (int i = 0; i < 4; i++)
      exp_xfer.push_back('{addr: 32'h300 + 32'(i * 4), we: 1'b0, wdata: 32'h0});
    tick();
    start_load = 1'b0;
    for (int lane = 0; lane < 2; lane++) begin
      mem_ack   = 1'b1;
      mem_rdata = 32'h7000_0000 + 32'(lane);
      tick();
    end
    mem_ack = 1'b0;
    rst     = 1'b0;
    #3;
    chk("pre_reset_req", mem_req, 1);
    tick();
    rst = 1'b1;
    exp_xfer.delete();
    last_load = '0;
    #3;
    chk("abort_req", mem_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_stuck", stuck, 0);
    chk("abort_load_data", load_data, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      #3;
      chk("abort_no_valid", load_valid, 0);
      chk("abort_idle", busy, 0);
      tick();
    end

    chk("xfer_queue_empty", 128'(exp_xfer.size()), 0);
    chk("load_queue_empty", 128'(exp_load.size()), 0);
    chk("store_queue_empty", 128'(exp_store.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vector_mem_sequencer.md
Name: vector_mem_sequencer

Overview:
- Multi-cycle sequencer for 128-bit vector loads and stores (AES state/key) over the 32-bit data-memory port.
- Split into LANES word transfers with a req/ack handshake.
- Drives the `Stuck` stall input of the decode/control path, so the pipeline freezes until the whole vector transfer completes.
- Sits between decode (MemData/MemSrc/MemWrite vector decodes) and data memory.

Parameters:
- LANES, 4, number of word lanes per vector.
- LANE_W, 32, width of one lane and of the memory data port.
- ADDR_W, 32, byte-address width.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-low reset.
- start_load  input  1  one-cycle request: vector load at base_addr.
- start_store  input  1  one-cycle request: vector store of store_data at base_addr.
- base_addr  input  ADDR_W  byte address of lane 0, sampled on accepted start.
- store_data  input  LANES*LANE_W  vector to store, lane 0 in bits [LANE_W-1:0], sampled on accepted start.
- mem_req  output  1  memory request valid.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  output  ADDR_W  lane byte address.
- mem_wdata  output  LANE_W  lane write data.
- mem_rdata  input  LANE_W  lane read data, valid with mem_ack on reads.
- mem_ack  input  1  memory accepts/completes the current lane this cycle.
- load_data  output  LANES*LANE_W  assembled load vector, lane 0 in the low bits.
- load_valid  output  1  one-cycle pulse: load_data complete.
- store_done  output  1  one-cycle pulse: all store lanes acknowledged.
- busy  output  1  state != IDLE.
- stuck  output  1  pipeline stall to the control unit.

Behaviour:
- Reset (rst=0 at clk edge):
  - state=IDLE, lane counter=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - load_data=0, load_valid=0, store_done=0, busy=0.
- Reset mid-transfer aborts immediately. No further mem_req; partial load_data is cleared.
- States: IDLE, XFER, DONE.
- IDLE:
  - start_load or start_store high: latch base_addr, store_data and direction (we); set lane=0; go to XFER.
  - Both starts high together: load wins, store is dropped.
- XFER:
  - mem_req=1, mem_we=latched direction, mem_addr=base+lane*(LANE_W/8), mem_wdata=store lane[lane].
  - Address arithmetic is modulo 2^ADDR_W; wrap-around is allowed with no error.
  - mem_req, mem_addr and mem_wdata hold stable until mem_ack.
  - On mem_ack during a load, capture mem_rdata into load_data lane[lane].
  - On mem_ack with lane==LANES-1, go to DONE. Otherwise lane++.
- DONE:
  - One cycle; mem_req=0.
  - load_valid=1 for a load, store_done=1 for a store.
  - Return to IDLE.
  - load_data holds its value until the next accepted load or reset.
- stuck is combinational: (start_load|start_store) in IDLE, OR state==XFER. It is low in DONE, so the stalled instruction advances in the DONE cycle.
- Latency: start at cycle t with zero-wait ack gives XFER t+1..t+LANES and DONE at t+LANES+1. stuck is high t..t+LANES. Each wait cycle without ack adds one cycle.
- Starts while state != IDLE are ignored.
- mem_ack while not in XFER is ignored.
- A start in the DONE cycle is ignored. Decode only re-issues it after the stall releases, which is the next cycle.

Decomposition:
- Package vms_pkg:
  - state enum vms_state_t {IDLE, XFER, DONE}.
  - constant LANE_BYTES = LANE_W/8.
  - lane-index width function clog2(LANES).
- One sub-module, vms_lane_buffer: LANES×LANE_W register file with lane-indexed write (load capture) and lane-indexed read mux (store data), with synchronous active-low clear. The FSM, counter and address generation stay in the top.

Test Plan:
- Zero-wait load: base=0x100, memory returns 0x11,0x22,0x33,0x44, ack every cycle.
  - mem_addr is 0x100,0x104,0x108,0x10C.
  - load_valid at t+5 with load_data=0x00000044_00000033_00000022_00000011.
  - stuck high t..t+4.
- Store with waits: base=0x200, store_data lanes A,B,C,D, ack delayed 2 cycles per lane.
  - mem_we=1 and address/data stable while waiting.
  - store_done pulses once, at t+13.
- Simultaneous start_load & start_store: only a read sequence occurs (mem_we=0), and no store_done.
- Wrap-around: base=0xFFFFFFF8 gives addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- Reset mid-transfer: rst=0 during lane 2 of a load.
  - Next cycle: mem_req=0, busy=0, stuck=0, load_data=0.
  - No load_valid.
- Ignored events:
  - A start during XFER causes no restart, and the lane count is unchanged.
  - A stray mem_ack in IDLE leaves all outputs unchanged.
